// File: rtl/input_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : input_arbiter
//  Description : Owns the player-input path into the game core. Selects
//                between the gamepad and the AI button source, auto-restarts
//                the game a fixed number of frames after a crash while the AI
//                is in control, and shapes AI jumps to a bounded hold length.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk                 in   system clock
//    rst                 in   asynchronous reset, active-high
//    frame_tick          in   one-cycle pulse per game frame
//    gamepad_is_present  in   gamepad attached
//    gamepad_start/up/down in raw gamepad buttons
//    ai_up               in   AI jump request (level)
//    ai_down             in   AI duck request (level)
//    crash               in   game-over level from the game core
//    button_start        out  start to game core (registered)
//    button_up           out  jump to game core (registered)
//    button_down         out  duck to game core (registered)
//    owner_pad           out  1 while the gamepad owns the input path
//    restart_pending     out  1 while an automatic restart is counting down
// ============================================================================
module input_arbiter #(
    parameter int IDLE_TIMEOUT  = 180,
    parameter int RESTART_DELAY = 60,
    parameter int MIN_JUMP      = 4,
    parameter int MAX_JUMP      = 20,
    parameter int CNT_W         = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_tick,
    input  logic gamepad_is_present,
    input  logic gamepad_start,
    input  logic gamepad_up,
    input  logic gamepad_down,
    input  logic ai_up,
    input  logic ai_down,
    input  logic crash,
    output logic button_start,
    output logic button_up,
    output logic button_down,
    output logic owner_pad,
    output logic restart_pending
);

    typedef enum logic [1:0] {
        ST_AI      = 2'd0,
        ST_PAD     = 2'd1,
        ST_RESTART = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_IDLE_TIMEOUT  = CNT_W'(IDLE_TIMEOUT);
    localparam logic [CNT_W-1:0] c_RESTART_DELAY = CNT_W'(RESTART_DELAY);
    localparam logic [CNT_W-1:0] c_MIN_JUMP      = CNT_W'(MIN_JUMP);
    localparam logic [CNT_W-1:0] c_MAX_JUMP      = CNT_W'(MAX_JUMP);
    localparam logic [CNT_W-1:0] c_CNT_MAX       = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_ONE           = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_ZERO          = {CNT_W{1'b0}};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_jcnt;
    logic [CNT_W-1:0] w_jcnt_nxt;
    logic [CNT_W-1:0] r_rcnt;
    logic [CNT_W-1:0] w_rcnt_nxt;
    logic [CNT_W-1:0] r_icnt;
    logic [CNT_W-1:0] w_icnt_nxt;
    logic             r_armed;
    logic             w_armed_nxt;
    logic             r_ai_up_q;
    logic             w_start_nxt;
    logic             w_up_nxt;
    logic             w_down_nxt;

    logic             w_pad_act;
    logic             w_ai_rise;
    logic [CNT_W-1:0] w_jcnt_step;
    logic [CNT_W-1:0] w_icnt_step;
    logic [CNT_W-1:0] w_rcnt_step;

    // Any press on an attached pad counts as player activity.
    assign w_pad_act = gamepad_is_present & (gamepad_start | gamepad_up | gamepad_down);

    // The edge detector tracks ai_up in every state, so a request held
    // across a RESTART or PAD episode does not count as a fresh jump.
    assign w_ai_rise = ai_up & ~r_ai_up_q;

    // Frame counters advance on frame_tick and saturate.
    assign w_jcnt_step = (frame_tick && (r_jcnt != c_CNT_MAX)) ? (r_jcnt + c_ONE) : r_jcnt;
    assign w_icnt_step = (frame_tick && (r_icnt != c_CNT_MAX)) ? (r_icnt + c_ONE) : r_icnt;
    assign w_rcnt_step = frame_tick ? (r_rcnt - c_ONE) : r_rcnt;

    always_comb begin
        w_state_nxt = r_state;
        w_jcnt_nxt  = r_jcnt;
        w_rcnt_nxt  = r_rcnt;
        w_icnt_nxt  = r_icnt;
        w_armed_nxt = r_armed;
        w_start_nxt = 1'b0;
        w_up_nxt    = 1'b0;
        w_down_nxt  = 1'b0;

        case (r_state)
            ST_AI: begin
                if (w_pad_act) begin
                    // Takeover beats a simultaneous crash; the pad is
                    // mirrored already in the takeover cycle.
                    w_state_nxt = ST_PAD;
                    w_icnt_nxt  = c_ZERO;
                    w_armed_nxt = 1'b0;
                    w_jcnt_nxt  = c_ZERO;
                    w_start_nxt = gamepad_start;
                    w_up_nxt    = gamepad_up;
                    w_down_nxt  = gamepad_down & ~gamepad_up;
                end else if (crash) begin
                    w_state_nxt = ST_RESTART;
                    w_rcnt_nxt  = c_RESTART_DELAY;
                    w_armed_nxt = 1'b0;
                    w_jcnt_nxt  = c_ZERO;
                end else begin
                    if (!r_armed && w_ai_rise) begin
                        w_armed_nxt = 1'b1;
                        w_jcnt_nxt  = c_ZERO;
                        w_up_nxt    = 1'b1;
                    end else if (r_armed) begin
                        // Hold at least MIN_JUMP frames; extend while the
                        // AI keeps asking, but never past MAX_JUMP frames.
                        w_jcnt_nxt  = w_jcnt_step;
                        w_up_nxt    = (w_jcnt_step < c_MIN_JUMP) |
                                      (ai_up & (w_jcnt_step < c_MAX_JUMP));
                        // Disarm when the jump ends; a new jump then
                        // requires a fresh rising edge of ai_up.
                        w_armed_nxt = w_up_nxt;
                    end
                    w_down_nxt = ai_down & ~w_up_nxt;
                end
            end

            ST_PAD: begin
                if (!gamepad_is_present) begin
                    w_state_nxt = ST_AI;
                end else if (w_pad_act) begin
                    w_icnt_nxt  = c_ZERO;
                    w_start_nxt = gamepad_start;
                    w_up_nxt    = gamepad_up;
                    w_down_nxt  = gamepad_down & ~gamepad_up;
                end else if (r_icnt == c_IDLE_TIMEOUT) begin
                    w_state_nxt = ST_AI;
                end else begin
                    // No press here means every gamepad button is low, so
                    // the mirrored outputs are already all zero.
                    w_icnt_nxt = w_icnt_step;
                end
            end

            ST_RESTART: begin
                if (w_pad_act) begin
                    w_state_nxt = ST_PAD;
                    w_icnt_nxt  = c_ZERO;
                    w_start_nxt = gamepad_start;
                    w_up_nxt    = gamepad_up;
                    w_down_nxt  = gamepad_down & ~gamepad_up;
                end else if (r_rcnt == c_ZERO) begin
                    w_start_nxt = 1'b1;
                    w_state_nxt = ST_AI;
                end else begin
                    w_rcnt_nxt = w_rcnt_step;
                end
            end

            default: begin
                w_state_nxt = ST_AI;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_AI;
            r_jcnt          <= c_ZERO;
            r_rcnt          <= c_ZERO;
            r_icnt          <= c_ZERO;
            r_armed         <= 1'b0;
            r_ai_up_q       <= 1'b0;
            button_start    <= 1'b0;
            button_up       <= 1'b0;
            button_down     <= 1'b0;
            owner_pad       <= 1'b0;
            restart_pending <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_jcnt          <= w_jcnt_nxt;
            r_rcnt          <= w_rcnt_nxt;
            r_icnt          <= w_icnt_nxt;
            r_armed         <= w_armed_nxt;
            r_ai_up_q       <= ai_up;
            button_start    <= w_start_nxt;
            button_up       <= w_up_nxt;
            button_down     <= w_down_nxt;
            owner_pad       <= (w_state_nxt == ST_PAD);
            restart_pending <= (w_state_nxt == ST_RESTART);
        end
    end

endmodule
`default_nettype wire
